// File: rtl/ram_bank.sv
// ram_bank: parametrised single-port data memory.
//
// Hardware zero-fill after reset or clr, byte-enable writes, and a
// READ_LATENCY-deep read pipeline. Out-of-range accesses raise err.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req, rw         request strobe, 1 = read / 0 = write
//   address         word address
//   data_in         write data
//   byte_en         per-byte write enables
//   clr             re-zero the whole array (enters INIT)
//   ready           a request can be accepted this cycle
//   data_out        read data; holds its last value when valid = 0
//   valid           one-cycle pulse: data_out carries a read result
//   err             one-cycle pulse: an accepted request was out of range
//   init_done       array contents are initialised
module ram_bank #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic                    rw,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic                    clr,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid,
    output logic                    err,
    output logic                    init_done
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra bit so DEPTH == 2**ADDR_WIDTH is still representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

    // Elaboration-time parameter sanity.
    if (DATA_WIDTH == 0 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("ram_bank: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (DEPTH < 2 || IDX_W > ADDR_WIDTH) begin : g_bad_depth
        $error("ram_bank: DEPTH must be in 2..2**ADDR_WIDTH");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("ram_bank: READ_LATENCY must be in 1..4");
    end

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    // One slot of the read/err pipeline.
    typedef struct packed {
        logic                  vld;
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
    } rd_slot_t;

    // Storage (no reset: contents are zeroed by the INIT sweep).
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_t                             state_q, state_d;
    logic [IDX_W-1:0]                   cnt_q, cnt_d;
    logic                               ready_q, ready_d;
    logic                               init_done_q, init_done_d;
    logic                               valid_q, valid_d;
    logic                               err_q, err_d;
    logic [DATA_WIDTH-1:0]              data_out_q, data_out_d;
    rd_slot_t [READ_LATENCY-1:0]        pipe_q, pipe_d;

    logic                               accept_c;
    logic                               in_range_c;
    logic [IDX_W-1:0]                   idx_c;
    logic [DATA_WIDTH-1:0]              rd_word_c;
    logic [DATA_WIDTH-1:0]              merged_c;
    logic                               mem_we_c;
    logic [IDX_W-1:0]                   mem_widx_c;
    logic [DATA_WIDTH-1:0]              mem_wdata_c;
    rd_slot_t                           issue_c;

    // Address decode and acceptance; ready_q is only ever high in IDLE.
    always_comb begin
        in_range_c = ({1'b0, address} < DEPTH_EXT);
        idx_c      = address[IDX_W-1:0];
        accept_c   = req && ready_q;
    end

    // Current word at the request address, and its byte-enable merge.
    always_comb begin
        rd_word_c = mem_q[idx_c];
        merged_c  = rd_word_c;
        for (int unsigned b = 0; b < NUM_BYTES; b++) begin
            if (byte_en[b]) begin
                merged_c[8*b +: 8] = data_in[8*b +: 8];
            end
        end
    end

    // Control: INIT sweep, request service, clr handling.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        init_done_d = init_done_q;
        mem_we_c    = 1'b0;
        mem_widx_c  = idx_c;
        mem_wdata_c = merged_c;
        issue_c     = '0;

        case (state_q)
            ST_INIT: begin
                mem_we_c    = 1'b1;
                mem_widx_c  = cnt_q;
                mem_wdata_c = '0;
                if (cnt_q == LAST_IDX) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    ready_d     = 1'b1;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end

            ST_IDLE: begin
                if (accept_c) begin
                    issue_c.err = !in_range_c;
                    if (rw) begin
                        issue_c.vld  = 1'b1;
                        issue_c.data = in_range_c ? rd_word_c : '0;
                    end else begin
                        mem_we_c = in_range_c;
                    end
                end
                // The request on this edge (if any) is served before clearing.
                if (clr) begin
                    state_d     = ST_INIT;
                    cnt_d       = '0;
                    ready_d     = 1'b0;
                    init_done_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    // Read pipeline keeps advancing in INIT so pre-clear reads still retire.
    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = issue_c;
        for (int k = int'(READ_LATENCY) - 1; k > 0; k--) begin
            pipe_d[k] = pipe_q[k-1];
        end
    end

    // Output stage: the final slot lands in the output registers.
    always_comb begin
        valid_d    = pipe_q[READ_LATENCY-1].vld;
        err_d      = pipe_q[READ_LATENCY-1].err;
        data_out_d = pipe_q[READ_LATENCY-1].vld ? pipe_q[READ_LATENCY-1].data
                                                : data_out_q;
    end

    // Control, pipeline and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            data_out_q  <= '0;
            pipe_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            data_out_q  <= data_out_d;
            pipe_q      <= pipe_d;
        end
    end

    // Array write port.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_widx_c] <= mem_wdata_c;
        end
    end

    assign ready     = ready_q;
    assign init_done = init_done_q;
    assign valid     = valid_q;
    assign err       = err_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_ram_bank.sv
// Scoreboard bench for ram_bank (DEPTH=16, READ_LATENCY=2).
module tb_ram_bank;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 16;
    localparam int unsigned DEP = 16;
    localparam int unsigned RL  = 2;
    localparam int unsigned NB  = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req;
    logic          rw;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in;
    logic [NB-1:0] byte_en;
    logic          clr;
    logic          ready;
    logic [DW-1:0] data_out;
    logic          valid;
    logic          err;
    logic          init_done;

    always #5 clk = ~clk;

    ram_bank #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .DEPTH       (DEP),
        .READ_LATENCY(RL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .rw       (rw),
        .address  (address),
        .data_in  (data_in),
        .byte_en  (byte_en),
        .clr      (clr),
        .ready    (ready),
        .data_out (data_out),
        .valid    (valid),
        .err      (err),
        .init_done(init_done)
    );

    typedef struct {
        int unsigned   cyc;
        logic          vld;
        logic          er;
        logic [DW-1:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int unsigned cyc      = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, want);
        end
    endfunction

    // Monitor: every output pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (valid === 1'b1 || err === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got valid=%b err=%b data=%h at cycle %0d, required no pulse",
                         valid, err, data_out, cyc);
            end else begin
                cur = sb.pop_front();
                check("out_cycle", 64'(cyc), 64'(cur.cyc));
                check("out_valid", 64'(valid), 64'(cur.vld));
                check("out_err", 64'(err), 64'(cur.er));
                if (cur.vld) check("out_data", 64'(data_out), 64'(cur.data));
            end
        end
    end

    // Issue one request at a negedge; it is accepted on the following posedge.
    task automatic op(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [NB-1:0] be, input logic [DW-1:0] exp_d);
        exp_t e;
        req     = 1'b1;
        rw      = r;
        address = a;
        data_in = d;
        byte_en = be;
        if (r || a >= AW'(DEP)) begin
            e.cyc  = cyc + 1 + RL;
            e.vld  = r;
            e.er   = (a >= AW'(DEP));
            e.data = (a >= AW'(DEP)) ? '0 : exp_d;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        req = 1'b0;
        clr = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    // Count edges until ready rises (bounded).
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (ready !== 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        req     = 1'b0;
        rw      = 1'b0;
        address = '0;
        data_in = '0;
        byte_en = '0;
        clr     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);

        // Initial zero-fill takes exactly DEPTH edges.
        rst_n = 1'b1;
        wait_ready(n);
        check("init_edges", 64'(n), 64'(DEP));
        check("init_done_high", 64'(init_done), 64'd1);

        op(1'b1, 16'd5, '0, '0, 32'd0);
        idle(4);

        // Back-to-back writes then reads.
        op(1'b0, 16'd0, 32'd10, 4'hF, '0);
        op(1'b0, 16'd1, 32'd20, 4'hF, '0);
        op(1'b0, 16'd2, 32'd30, 4'hF, '0);
        op(1'b0, 16'd3, 32'd40, 4'hF, '0);
        op(1'b1, 16'd0, '0, '0, 32'd10);
        op(1'b1, 16'd1, '0, '0, 32'd20);
        op(1'b1, 16'd2, '0, '0, 32'd30);
        op(1'b1, 16'd3, '0, '0, 32'd40);
        idle(4);

        // Byte enables, with read-after-write on the next cycle.
        op(1'b0, 16'd7, 32'hAABBCCDD, 4'hF, '0);
        op(1'b0, 16'd7, 32'h11223344, 4'b0101, '0);
        op(1'b1, 16'd7, '0, '0, 32'hAA22CC44);
        op(1'b0, 16'd9, 32'h12345678, 4'h0, '0);
        op(1'b1, 16'd9, '0, '0, 32'd0);
        idle(4);

        // Out of range: write dropped (no alias onto word 0), read gives err.
        op(1'b0, 16'd16, 32'd99, 4'hF, '0);
        idle(4);
        op(1'b1, 16'd16, '0, '0, '0);
        op(1'b1, 16'd15, '0, '0, 32'd0);
        op(1'b1, 16'd0, '0, '0, 32'd10);
        op(1'b1, 16'hFFFF, '0, '0, '0);
        idle(4);

        // Clear with a same-edge read: read sees pre-clear data.
        op(1'b0, 16'd3, 32'd55, 4'hF, '0);
        clr = 1'b1;
        op(1'b1, 16'd3, '0, '0, 32'd55);
        req = 1'b0;
        clr = 1'b0;
        wait_ready(n);
        check("clr_ready_low_cycles", 64'(n), 64'(DEP));
        check("clr_init_done", 64'(init_done), 64'd1);
        op(1'b1, 16'd3, '0, '0, 32'd0);
        op(1'b1, 16'd7, '0, '0, 32'd0);
        idle(4);

        // Reset while a read is in flight: it must be discarded.
        op(1'b0, 16'd4, 32'hCAFE0001, 4'hF, '0);
        req     = 1'b1;
        rw      = 1'b1;
        address = 16'd4;
        @(negedge clk);
        req   = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(valid), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        check("midrst_data_out", 64'(data_out), 64'd0);
        check("midrst_ready", 64'(ready), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n);
        check("reinit_edges", 64'(n), 64'(DEP));
        op(1'b1, 16'd4, '0, '0, 32'd0);
        op(1'b1, 16'd1, '0, '0, 32'd0);
        idle(6);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
